// File: rtl/fetch_seq.sv
// Byte-serial instruction fetch stage: owns the PC, reads one byte per memory handshake and
// decodes length/fields. Optional halt lock is enabled by defining FETCH_HALT_LOCK_EN.
module fetch_seq #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_load,
    input  logic [63:0] updated_PC,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error,
    output logic        busy,
    output logic        fetch_done,
    output logic [2:0]  dbg_state
);

    // Memory handshake: a byte moves on a rising edge where mem_req && mem_ready; while
    // mem_req is high, mem_addr is held and mem_rdata is taken in the same cycle as mem_ready.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_B0    = 3'd1,
        S_REG   = 3'd2,
        S_CONST = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

    state_t      state;
    state_t      after_state;
    logic [2:0]  cidx;
    logic        xfer;
    logic [63:0] next_addr;
    logic        next_ok;
    logic        load_ok;

    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
            4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
            4'h7, 4'h8:             instr_len = 4'd9;
            default:                instr_len = 4'd1;
        endcase
    endfunction

    function automatic logic has_reg(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_reg = 1'b1;
            default:                                  has_reg = 1'b0;
        endcase
    endfunction

    function automatic logic has_const(input logic [3:0] ic);
        case (ic)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: has_const = 1'b1;
            default:                      has_const = 1'b0;
        endcase
    endfunction

    assign dbg_state = state;

    always_comb begin
        xfer      = mem_req & mem_ready;
        next_addr = mem_addr + 64'd1;
        next_ok   = next_addr < MEM_LIMIT;
        after_state = S_DONE;
        case (state)
            S_B0: begin
                if (has_reg(mem_rdata[7:4]))
                    after_state = S_REG;
                else if (has_const(mem_rdata[7:4]))
                    after_state = S_CONST;
                else
                    after_state = S_DONE;
            end
            S_REG:   after_state = has_const(icode) ? S_CONST : S_DONE;
            S_CONST: after_state = (cidx == 3'd7) ? S_DONE : S_CONST;
            default: after_state = S_DONE;
        endcase
    end

`ifdef FETCH_HALT_LOCK_EN
    logic halted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            halted <= 1'b0;
        else if (state == S_DONE && icode == 4'h0 && instr_valid)
            halted <= 1'b1;
    end

    assign load_ok = ~halted;
`else
    assign load_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cidx        <= 3'd0;
            pc          <= 64'd0;
            mem_req     <= 1'b0;
            mem_addr    <= 64'd0;
            icode       <= 4'h0;
            ifun        <= 4'h0;
            rA          <= 4'hF;
            rB          <= 4'hF;
            valC        <= 64'd0;
            valP        <= 64'd0;
            instr_valid <= 1'b0;
            imem_error  <= 1'b0;
            busy        <= 1'b0;
            fetch_done  <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pc_load && load_ok) begin
                        // Unfetched bytes read as 0, so defaults describe a 1-byte halt.
                        pc          <= updated_PC;
                        mem_addr    <= updated_PC;
                        cidx        <= 3'd0;
                        icode       <= 4'h0;
                        ifun        <= 4'h0;
                        rA          <= 4'hF;
                        rB          <= 4'hF;
                        valC        <= 64'd0;
                        valP        <= updated_PC + 64'd1;
                        instr_valid <= 1'b0;
                        imem_error  <= 1'b0;
                        if (updated_PC < MEM_LIMIT) begin
                            state   <= S_B0;
                            mem_req <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            state      <= S_DONE;
                            imem_error <= 1'b1;
                            busy       <= 1'b0;
                            fetch_done <= 1'b1;
                        end
                    end
                end
                S_B0, S_REG, S_CONST: begin
                    if (xfer) begin
                        case (state)
                            S_B0: begin
                                icode       <= mem_rdata[7:4];
                                ifun        <= mem_rdata[3:0];
                                instr_valid <= (mem_rdata[7:4] <= 4'hB);
                                valP        <= pc + {60'd0, instr_len(mem_rdata[7:4])};
                                if (has_reg(mem_rdata[7:4])) begin
                                    rA <= 4'h0;
                                    rB <= 4'h0;
                                end
                            end
                            S_REG: begin
                                rA <= mem_rdata[7:4];
                                rB <= mem_rdata[3:0];
                            end
                            S_CONST: begin
                                valC[{cidx, 3'b000} +: 8] <= mem_rdata;
                                cidx                      <= cidx + 3'd1;
                            end
                            default: ;
                        endcase
                        // The next request is range-checked here so an illegal address is never driven.
                        if (after_state == S_DONE || !next_ok) begin
                            state      <= S_DONE;
                            mem_req    <= 1'b0;
                            busy       <= 1'b0;
                            fetch_done <= 1'b1;
                            imem_error <= (after_state != S_DONE);
                        end else begin
                            state    <= after_state;
                            mem_addr <= next_addr;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a vector table of instructions with hand-computed decode
// results, plus sequences for reset mid-fetch, ignored loads while busy and the halt lock.
module tb_fetch_seq;

    localparam int MEMB = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_load;
    logic [63:0] updated_PC;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic [63:0] pc;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_valid, imem_error, busy, fetch_done;
    logic [2:0]  dbg_state;

    fetch_seq #(.MEM_BYTES(MEMB)) dut (
        .clk(clk), .reset(reset), .pc_load(pc_load), .updated_PC(updated_PC),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .pc(pc), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .instr_valid(instr_valid), .imem_error(imem_error), .busy(busy),
        .fetch_done(fetch_done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:MEMB-1];
    assign mem_rdata = (mem_addr < 64'(MEMB)) ? mem[mem_addr[11:0]] : 8'h00;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [63:0] pc;
        int          nb;
        logic [79:0] bytes;
        int          waits;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        valid, err;
        int          xfers;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_bytes(input logic [63:0] base, input int nb, input logic [79:0] bytes);
        logic [63:0] a;
        for (int i = 0; i < nb; i++) begin
            a = base + 64'(i);
            if (a < 64'(MEMB)) mem[a[11:0]] = bytes[8*(nb-1-i) +: 8];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; pc_load = 1'b0; mem_ready = 1'b0; updated_PC = 64'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int xf, dc, wl;
        logic was_wait;
        logic [63:0] last_addr;
        string tag;
        tag = $sformatf("v%0d", idx);
        load_bytes(v.pc, v.nb, v.bytes);
        exp_q.delete();
        for (int i = 0; i < v.xfers; i++) exp_q.push_back(v.pc + 64'(i));
        @(negedge clk);
        updated_PC = v.pc; pc_load = 1'b1; mem_ready = 1'b0;
        @(posedge clk);
        #1 pc_load = 1'b0;
        xf = 0; dc = 0; wl = v.waits; was_wait = 1'b0; last_addr = 64'd0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check({tag, "_busy1"}, 64'(busy), 64'(v.xfers != 0));
                check({tag, "_req1"}, 64'(mem_req), 64'(v.xfers != 0));
            end
            if (fetch_done) begin
                dc = c;
                break;
            end
            if (was_wait && mem_req) check({tag, "_addr_hold"}, mem_addr, last_addr);
            if (mem_req) check({tag, "_req_in_range"}, 64'(mem_addr >= 64'(MEMB)), 64'd0);
            if (mem_req && wl > 0) begin
                mem_ready = 1'b0; wl--; was_wait = 1'b1; last_addr = mem_addr;
            end else begin
                mem_ready = 1'b1; was_wait = 1'b0;
                if (mem_req) begin
                    xf++;
                    if (exp_q.size() == 0) check({tag, "_extra_xfer"}, mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                    else check({tag, "_xfer_addr"}, mem_addr, exp_q.pop_front());
                end
            end
        end
        mem_ready = 1'b0;
        check({tag, "_done_cycle"}, 64'(dc), 64'(v.xfers + v.waits + 1));
        check({tag, "_xfers"}, 64'(xf), 64'(v.xfers));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_pc"}, pc, v.pc);
        check({tag, "_icode"}, 64'(icode), 64'(v.icode));
        check({tag, "_ifun"}, 64'(ifun), 64'(v.ifun));
        check({tag, "_rA"}, 64'(rA), 64'(v.ra));
        check({tag, "_rB"}, 64'(rB), 64'(v.rb));
        check({tag, "_valC"}, valC, v.valc);
        check({tag, "_valP"}, valP, v.valp);
        check({tag, "_valid"}, 64'(instr_valid), 64'(v.valid));
        check({tag, "_err"}, 64'(imem_error), 64'(v.err));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_pulse_end"}, 64'(fetch_done), 64'd0);
        check({tag, "_hold_valP"}, valP, v.valp);
    endtask

    initial begin
        int dc;
        int saw_done, saw_busy;
        for (int i = 0; i < MEMB; i++) mem[i] = 8'h00;
        reset = 1'b1; pc_load = 1'b0; mem_ready = 1'b0; updated_PC = 64'd0;

        // Reset state
        do_reset();
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_pc", pc, 64'd0);
        check("rst_valC", valC, 64'd0);
        check("rst_valP", valP, 64'd0);
        check("rst_icode_ifun", 64'({icode, ifun}), 64'h00);
        check("rst_rA_rB", 64'({rA, rB}), 64'hFF);
        check("rst_flags", 64'({mem_req, busy, fetch_done, instr_valid, imem_error}), 64'd0);

        // pc, nb, bytes, waits, icode, ifun, rA, rB, valC, valP, valid, err, xfers
        vecs.push_back('{64'h0, 10, 80'h30F40102030405060708, 0, 4'h3, 4'h0, 4'hF, 4'h4,
                         64'h0807060504030201, 64'd10, 1'b1, 1'b0, 10});
        vecs.push_back('{64'h20, 9, 80'h700001000000000000, 0, 4'h7, 4'h0, 4'hF, 4'hF,
                         64'h100, 64'h29, 1'b1, 1'b0, 9});
        vecs.push_back('{64'h5, 1, 80'h90, 3, 4'h9, 4'h0, 4'hF, 4'hF,
                         64'h0, 64'h6, 1'b1, 1'b0, 1});
        vecs.push_back('{64'h40, 1, 80'hE0, 0, 4'hE, 4'h0, 4'hF, 4'hF,
                         64'h0, 64'h41, 1'b0, 1'b0, 1});
        vecs.push_back('{64'(MEMB - 4), 4, 80'h80112233, 0, 4'h8, 4'h0, 4'hF, 4'hF,
                         64'h332211, 64'(MEMB + 5), 1'b1, 1'b1, 4});
        vecs.push_back('{64'h60, 2, 80'h6012, 2, 4'h6, 4'h0, 4'h1, 4'h2,
                         64'h0, 64'h62, 1'b1, 1'b0, 2});
        vecs.push_back('{64'h80, 10, 80'h5037AABBCCDDEEFF1122, 1, 4'h5, 4'h0, 4'h3, 4'h7,
                         64'h2211FFEEDDCCBBAA, 64'h8A, 1'b1, 1'b0, 10});
        vecs.push_back('{64'(MEMB - 2), 2, 80'hB03F, 0, 4'hB, 4'h0, 4'h3, 4'hF,
                         64'h0, 64'(MEMB), 1'b1, 1'b0, 2});
        vecs.push_back('{64'(MEMB - 1), 1, 80'hA0, 0, 4'hA, 4'h0, 4'h0, 4'h0,
                         64'h0, 64'(MEMB + 1), 1'b1, 1'b1, 1});
        vecs.push_back('{64'(MEMB), 0, 80'h0, 0, 4'h0, 4'h0, 4'hF, 4'hF,
                         64'h0, 64'(MEMB + 1), 1'b0, 1'b1, 0});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 0, 80'h0, 0, 4'h0, 4'h0, 4'hF, 4'hF,
                         64'h0, 64'h0, 1'b0, 1'b1, 0});
        vecs.push_back('{64'h100, 1, 80'h00, 0, 4'h0, 4'h0, 4'hF, 4'hF,
                         64'h0, 64'h101, 1'b1, 1'b0, 1});

        foreach (vecs[i]) run_vec(vecs[i], i);

        // After the halt fetch: a new load is either locked out or honoured.
        @(negedge clk);
        updated_PC = 64'h20; pc_load = 1'b1; mem_ready = 1'b1;
        @(posedge clk);
        #1 pc_load = 1'b0;
        saw_done = 0; saw_busy = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (fetch_done) saw_done++;
            if (busy) saw_busy++;
        end
        mem_ready = 1'b0;
`ifdef FETCH_HALT_LOCK_EN
        check("lock_no_done", 64'(saw_done), 64'd0);
        check("lock_no_busy", 64'(saw_busy), 64'd0);
        check("lock_pc", pc, 64'h100);
`else
        check("nolock_done", 64'(saw_done), 64'd1);
        check("nolock_pc", pc, 64'h20);
        check("nolock_valP", valP, 64'h29);
`endif

        // pc_load while busy is ignored.
        do_reset();
        load_bytes(64'h200, 10, 80'h30F40102030405060708);
        updated_PC = 64'h200; pc_load = 1'b1; mem_ready = 1'b1;
        @(posedge clk);
        #1 pc_load = 1'b0;
        dc = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 3) begin pc_load = 1'b1; updated_PC = 64'h700; end
            else pc_load = 1'b0;
            if (fetch_done) begin dc = c; break; end
        end
        pc_load = 1'b0; mem_ready = 1'b0;
        check("ign_done_cycle", 64'(dc), 64'd11);
        check("ign_pc", pc, 64'h200);
        check("ign_valP", valP, 64'h20A);
        check("ign_valC", valC, 64'h0807060504030201);

        // Reset asserted while in CONST clears everything at once, no completion follows.
        @(negedge clk);
        updated_PC = 64'h200; pc_load = 1'b1; mem_ready = 1'b1;
        @(posedge clk);
        #1 pc_load = 1'b0;
        for (int c = 1; c <= 5; c++) @(negedge clk);
        check("mid_state_const", 64'(dbg_state), 64'd3);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        check("mid_rst_pc", pc, 64'd0);
        check("mid_rst_vals", {valC[31:0], valP[31:0]}, 64'd0);
        check("mid_rst_fields", 64'({icode, ifun, rA, rB}), 64'h00FF);
        check("mid_rst_flags", 64'({mem_req, busy, fetch_done, instr_valid, imem_error}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (fetch_done || busy || mem_req) saw_done++;
        end
        mem_ready = 1'b0;
        check("mid_no_done", 64'(saw_done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
